mux2_arbiter: RTL and testbench
===============================

// Module: mux2_arbiter
// PURPOSE
//  Round-robin arbiter sharing one 32-bit output channel between two requesters (A, B).
//  Drives the select of the downstream 2:1 datapath mux (sel=0 -> A, sel=1 -> B).
//  Grants whole bursts (valid/ready/last handshake) and registers the muxed beat into a one-deep output stage.
//  Sits between two producers (e.g. ALU result / memory read path) and a single consumer port.
// PARAMETERS
//  WIDTH      32  data width of each requester and of the output
//  MAX_BURST  8   beats before forced release (used only with ARB_PREEMPT_EN), >=1
//  CNT_W      4   beat-counter width, must satisfy 2**CNT_W > MAX_BURST
// PORTS
//  clk        in   1      rising-edge clock, single clock domain
//  rst_n      in   1      asynchronous active-low reset
//  a_valid    in   1      requester A beat valid
//  a_data     in   WIDTH  requester A beat data
//  a_last     in   1      final beat of A's burst
//  a_ready    out  1      A beat accepted this cycle
//  b_valid    in   1      requester B beat valid
//  b_data     in   WIDTH  requester B beat data
//  b_last     in   1      final beat of B's burst
//  b_ready    out  1      B beat accepted this cycle
//  out_valid  out  1      output beat valid (registered)
//  out_data   out  WIDTH  output beat data (registered)
//  out_last   out  1      output beat is last of burst (registered)
//  out_ready  in   1      consumer accepts output beat
//  sel        out  1      mux select, registered; 0=A, 1=B; valid while granted
//  grant_a    out  1      FSM in BUSY_A
//  grant_b    out  1      FSM in BUSY_B
// BEHAVIOUR
//  - Reset (async, rst_n=0): state=IDLE, ptr=0 (A has priority), sel=0, beat_cnt=0; every output 0 (out_valid, out_data, out_last, a_ready, b_ready, grant_a, grant_b). Any burst in flight is dropped with no resume.
//  - States: IDLE, BUSY_A, BUSY_B.
//  - IDLE: only A valid -> BUSY_A; only B valid -> BUSY_B; both valid -> A if ptr=0 else B; none -> stay. sel updates on the grant edge.
//  - Arbitration costs 1 cycle. No ready is asserted in IDLE.
//  - slot_free = !out_valid || out_ready.
//  - a_ready = (state==BUSY_A) && slot_free. b_ready is symmetric.
//  - A beat transfers when valid && ready. The next edge loads out_data/out_last from the granted source and sets out_valid=1. Source-to-output latency is 1 cycle.
//  - out_valid clears on out_ready when no new beat is loaded. Output holds stable while out_valid && !out_ready.
//  - Transferred beat with last=1: next state IDLE; ptr <= !granted (other side wins next tie); beat_cnt <= 0.
//  - Back-to-back: with both requesters continuously valid and out_ready=1, bursts alternate A,B,A,... with exactly one idle arbitration cycle between them.
//  - Valid dropped mid-burst: grant is held, no beats move, the FSM waits.
//  - beat_cnt increments per transferred beat and saturates at MAX_BURST.
//  - out_data is the registered output of sel ? b_data : a_data, sampled only on transfer.
// CONFIGURATION
//  ARB_PREEMPT_EN defined:
//   - When a transferred beat makes beat_cnt reach MAX_BURST while the other requester is valid, the grant is released after that beat (-> IDLE, ptr flips) even if last=0.
//   - out_last still reflects the source's last only.
//   - The preempted requester resumes its burst at its next grant.
//  ARB_PREEMPT_EN undefined:
//   - Grant is held until the last beat, regardless of burst length.
//   - MAX_BURST is ignored. beat_cnt may be omitted.
// TESTING
//  1. Reset: rst_n=0 mid-burst, asynchronously in the cycle -> all outputs 0 immediately; after release with a_valid=1, grant_a=1 one cycle later.
//  2. Single A: 3-beat burst 0x11,0x22,0x33 (last on 0x33), out_ready=1 -> out_data 0x11,0x22,0x33 on consecutive cycles, out_last only on 0x33, sel=0, back to IDLE.
//  3. Contention: A and B both valid from reset, 2-beat bursts each, repeated -> grant order A,B,A,B; one arbitration cycle between bursts.
//  4. Backpressure: out_ready=0 for 4 cycles mid-burst -> out_data held, a_ready=0, no beat lost or duplicated; the stream resumes in order.
//  5. Preempt (ARB_PREEMPT_EN, MAX_BURST=8): A sends a 20-beat burst while B waits -> A releases after beat 8, B served, then A resumes at beat 9. Without the macro, all 20 A beats go out before B.
//  6. Mid-burst idle: A deasserts a_valid for 3 cycles with B valid -> grant_a stays 1, b_ready stays 0.

Source files
------------

// File: rtl/mux2_arbiter.sv
// rtl/mux2_arbiter.sv - two-requester round-robin burst arbiter with registered output stage
//
// Shares one WIDTH-bit output channel between requesters A and B. Whole bursts
// are granted (valid/ready/last handshake); each transferred beat is registered
// into a one-deep output stage. sel drives the downstream 2:1 datapath mux
// (0 = A, 1 = B).
//
// Optional feature macro: ARB_PREEMPT_EN
//   defined   - a grant is released after MAX_BURST beats if the other side waits
//   undefined - a grant is held until the source's last beat
//
// Ports:
//   clk, rst_n                    clock, asynchronous active-low reset
//   a_valid/a_data/a_last/a_ready requester A beat handshake
//   b_valid/b_data/b_last/b_ready requester B beat handshake
//   out_valid/out_data/out_last   registered output beat
//   out_ready                     consumer accepts output beat
//   sel                           registered mux select, valid while granted
//   grant_a/grant_b               arbiter currently serving A / B
module mux2_arbiter #(
  parameter int WIDTH     = 32,
  parameter int MAX_BURST = 8,
  parameter int CNT_W     = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             a_valid,
  input  logic [WIDTH-1:0] a_data,
  input  logic             a_last,
  output logic             a_ready,
  input  logic             b_valid,
  input  logic [WIDTH-1:0] b_data,
  input  logic             b_last,
  output logic             b_ready,
  output logic             out_valid,
  output logic [WIDTH-1:0] out_data,
  output logic             out_last,
  input  logic             out_ready,
  output logic             sel,
  output logic             grant_a,
  output logic             grant_b
);

  // Reject configurations where the beat counter cannot hold MAX_BURST.
  generate
    if (MAX_BURST < 1 || (2 ** CNT_W) <= MAX_BURST) begin : g_bad_cfg
      $error("mux2_arbiter: need MAX_BURST >= 1 and 2**CNT_W > MAX_BURST");
    end
  endgenerate

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    BUSY_A = 2'd1,
    BUSY_B = 2'd2
  } state_t;

  state_t state, state_nxt;
  logic   ptr, ptr_nxt;   // 0: A wins a tie, 1: B wins a tie
  logic   sel_nxt;

  logic slot_free;
  logic a_xfer, b_xfer, xfer, xfer_last;
  logic preempt;
  logic release_grant;

  // The output slot can take a beat when empty or being drained this cycle.
  assign slot_free = !out_valid || out_ready;
  assign a_ready   = (state == BUSY_A) && slot_free;
  assign b_ready   = (state == BUSY_B) && slot_free;
  assign grant_a   = (state == BUSY_A);
  assign grant_b   = (state == BUSY_B);

  assign a_xfer    = a_valid && a_ready;
  assign b_xfer    = b_valid && b_ready;
  assign xfer      = a_xfer || b_xfer;
  assign xfer_last = (a_xfer && a_last) || (b_xfer && b_last);

`ifdef ARB_PREEMPT_EN
  logic [CNT_W-1:0] beat_cnt;
  logic [CNT_W-1:0] cnt_inc;
  logic             other_valid;

  // Saturating count of beats moved in the current grant.
  assign cnt_inc     = (beat_cnt >= CNT_W'(MAX_BURST)) ? CNT_W'(MAX_BURST)
                                                       : beat_cnt + 1'b1;
  assign other_valid = (state == BUSY_A) ? b_valid : a_valid;
  // Release only when the other side is actually waiting; a lone requester
  // keeps streaming with the counter parked at MAX_BURST.
  assign preempt     = xfer && (cnt_inc == CNT_W'(MAX_BURST)) && other_valid;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      beat_cnt <= '0;
    end else if (release_grant) begin
      beat_cnt <= '0;
    end else if (xfer) begin
      beat_cnt <= cnt_inc;
    end
  end
`else
  assign preempt = 1'b0;
`endif

  assign release_grant = xfer_last || preempt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      ptr   <= 1'b0;
      sel   <= 1'b0;
    end else begin
      state <= state_nxt;
      ptr   <= ptr_nxt;
      sel   <= sel_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    ptr_nxt   = ptr;
    sel_nxt   = sel;
    case (state)
      IDLE: begin
        if (a_valid && (!b_valid || !ptr)) begin
          state_nxt = BUSY_A;
          sel_nxt   = 1'b0;
        end else if (b_valid) begin
          state_nxt = BUSY_B;
          sel_nxt   = 1'b1;
        end
      end
      BUSY_A: begin
        if (release_grant) begin
          state_nxt = IDLE;
          ptr_nxt   = 1'b1;
        end
      end
      BUSY_B: begin
        if (release_grant) begin
          state_nxt = IDLE;
          ptr_nxt   = 1'b0;
        end
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

  // One-deep output register; holds its beat while the consumer stalls.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      out_data  <= '0;
      out_last  <= 1'b0;
    end else if (xfer) begin
      out_valid <= 1'b1;
      out_data  <= sel ? b_data : a_data;
      out_last  <= sel ? b_last : a_last;
    end else if (out_ready) begin
      out_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_mux2_arbiter.sv
// tb/tb_mux2_arbiter.sv - scoreboard bench for mux2_arbiter
module tb_mux2_arbiter;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        a_valid, a_last, a_ready;
  logic [31:0] a_data;
  logic        b_valid, b_last, b_ready;
  logic [31:0] b_data;
  logic        out_valid, out_last, out_ready;
  logic [31:0] out_data;
  logic        sel, grant_a, grant_b;

  mux2_arbiter #(.WIDTH(32), .MAX_BURST(8), .CNT_W(4)) dut (
    .clk(clk), .rst_n(rst_n),
    .a_valid(a_valid), .a_data(a_data), .a_last(a_last), .a_ready(a_ready),
    .b_valid(b_valid), .b_data(b_data), .b_last(b_last), .b_ready(b_ready),
    .out_valid(out_valid), .out_data(out_data), .out_last(out_last),
    .out_ready(out_ready), .sel(sel), .grant_a(grant_a), .grant_b(grant_b)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int checks = 0;
  int errors = 0;

  // Expected beats per source, {last, data}; bit 31 of data tags the source.
  logic [32:0] qa[$];
  logic [32:0] qb[$];
  int          log_cyc[$];
  bit          log_src[$];
  bit          mon_en = 1'b0;
  bit          mon_in_burst = 1'b0;
  bit          mon_cur_src = 1'b0;
  bit          done_a, done_b;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Monitor: every accepted output beat is popped from its source's queue.
  always @(negedge clk) begin : monitor
    logic        src;
    logic [32:0] e;
    if (mon_en && rst_n && out_valid && out_ready) begin
      src = out_data[31];
      if ((src ? qb.size() : qa.size()) == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_beat actual=%0h required=none src=%0d", out_data, src);
      end else begin
        e = src ? qb.pop_front() : qa.pop_front();
        chk(src ? "b_beat" : "a_beat", {31'd0, out_last, out_data}, {31'd0, e});
      end
`ifndef ARB_PREEMPT_EN
      if (mon_in_burst) chk("burst_atomic", src, mon_cur_src);
`endif
      mon_cur_src  = src;
      mon_in_burst = !out_last;
      log_cyc.push_back(cyc);
      log_src.push_back(src);
    end
  end

  task automatic drive(input bit src, input logic v, input logic [31:0] d, input logic l);
    if (src) begin
      b_valid = v; b_data = d; b_last = l;
    end else begin
      a_valid = v; a_data = d; a_last = l;
    end
  endtask

  // Sends one burst. fixed!=0 gives data fixed*(i+1); gap_at inserts a
  // 3-cycle valid drop before that beat and checks the grant is held.
  task automatic send_burst(input bit src, input int len, input int gapmax,
                            input logic [31:0] fixed, input int gap_at);
    logic [31:0] d, r;
    int          g, t;
    for (int i = 0; i < len; i++) begin
      r = $urandom();
      d = (fixed != 0) ? fixed * (i + 1) : r;
      d[31] = src;
      if (src) qb.push_back({i == len - 1, d});
      else     qa.push_back({i == len - 1, d});
      g = (i == gap_at) ? 3 : ((gapmax > 0) ? $urandom_range(0, gapmax) : 0);
      repeat (g) begin
        @(negedge clk);
        if (i == gap_at) begin
          chk("hold_grant", src ? grant_b : grant_a, 1);
          chk("other_ready", src ? a_ready : b_ready, 0);
        end
        @(posedge clk); #1;
      end
      drive(src, 1'b1, d, i == len - 1);
      t = 0;
      forever begin
        @(negedge clk);
        if (src ? b_ready : a_ready) break;
        t++;
        if (t > 2000) begin
          checks++;
          errors++;
          $display("FAIL ready_timeout actual=0 required=1 src=%0d", src);
          break;
        end
      end
      @(posedge clk); #1;
      drive(src, 1'b0, 32'd0, 1'b0);
    end
  endtask

  task automatic apply_reset();
    rst_n = 1'b0;
    drive(1'b0, 1'b0, 32'd0, 1'b0);
    drive(1'b1, 1'b0, 32'd0, 1'b0);
    out_ready = 1'b1;
    repeat (2) begin @(posedge clk); #1; end
    qa.delete();
    qb.delete();
    log_cyc.delete();
    log_src.delete();
    rst_n = 1'b1;
  endtask

  task automatic drain_and_clear();
    repeat (6) begin @(posedge clk); #1; end
    chk("qa_empty", qa.size(), 0);
    chk("qb_empty", qb.size(), 0);
  endtask

  initial begin : watchdog
    #500000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1);
  end

  initial begin : main
    bit exp_src;
    // Reset state and asynchronous reset mid-burst.
    apply_reset();
    chk("reset_outputs", {out_valid, out_last, a_ready, b_ready, grant_a, grant_b, sel, out_data}, 0);
    a_valid = 1'b1; a_data = 32'h5; a_last = 1'b0;
    repeat (3) begin @(posedge clk); #1; end
    chk("pre_reset_busy", {grant_a, out_valid}, 2'b11);
    #1 rst_n = 1'b0;
    #1;
    chk("async_reset_outputs", {out_valid, out_last, a_ready, b_ready, grant_a, grant_b, sel, out_data}, 0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    chk("grant_after_release_0", grant_a, 0);
    @(posedge clk); #1;
    chk("grant_after_release_1", grant_a, 1);
    apply_reset();
    mon_en = 1'b1;

    // Single A burst 0x11, 0x22, 0x33.
    send_burst(1'b0, 3, 0, 32'h11, -1);
    drain_and_clear();
    chk("single_count", log_cyc.size(), 3);
    for (int i = 1; i < 3 && i < log_cyc.size(); i++)
      chk("single_consecutive", log_cyc[i] - log_cyc[i-1], 1);
    chk("single_sel", sel, 0);
    chk("single_idle", {grant_a, grant_b}, 2'b00);

    // Contention from reset: A,B,A,B,... with one arbitration cycle between.
    apply_reset();
    fork
      repeat (3) send_burst(1'b0, 2, 0, 32'd0, -1);
      repeat (3) send_burst(1'b1, 2, 0, 32'd0, -1);
    join
    drain_and_clear();
    chk("rr_count", log_cyc.size(), 12);
    for (int i = 0; i < 12 && i < log_src.size(); i++) begin
      chk("rr_src", log_src[i], (i / 2) % 2);
      if (i > 0) chk("rr_gap", log_cyc[i] - log_cyc[i-1], (i % 2 == 0) ? 2 : 1);
    end

    // Backpressure mid-burst.
    log_cyc.delete(); log_src.delete();
    fork
      send_burst(1'b0, 6, 0, 32'd0, -1);
      begin : stall
        logic [31:0] hold;
        repeat (3) @(posedge clk);
        #1 out_ready = 1'b0;
        @(negedge clk);
        hold = out_data;
        chk("bp_valid", out_valid, 1);
        repeat (4) begin
          @(negedge clk);
          chk("bp_hold", out_data, hold);
          chk("bp_a_ready", a_ready, 0);
        end
        @(posedge clk); #1 out_ready = 1'b1;
      end
    join
    drain_and_clear();
    chk("bp_count", log_cyc.size(), 6);

    // Long A burst while B waits.
    log_cyc.delete(); log_src.delete();
    fork
      send_burst(1'b0, 20, 0, 32'd0, -1);
      begin
        repeat (2) @(posedge clk);
        #1 send_burst(1'b1, 2, 0, 32'd0, -1);
      end
    join
    drain_and_clear();
    chk("long_count", log_src.size(), 22);
    for (int i = 0; i < 22 && i < log_src.size(); i++) begin
`ifdef ARB_PREEMPT_EN
      exp_src = (i >= 8 && i < 10);
`else
      exp_src = (i >= 20);
`endif
      chk("long_order", log_src[i], exp_src);
    end

    // A drops valid mid-burst while B waits.
    fork
      send_burst(1'b0, 4, 0, 32'd0, 2);
      begin
        repeat (3) @(posedge clk);
        #1 send_burst(1'b1, 2, 0, 32'd0, -1);
      end
    join
    drain_and_clear();

    // Randomized traffic with random consumer stalls.
    done_a = 1'b0; done_b = 1'b0;
    fork
      begin
        repeat (25) send_burst(1'b0, ($urandom_range(0, 7) == 0) ? 12 : $urandom_range(1, 6), 2, 32'd0, -1);
        done_a = 1'b1;
      end
      begin
        repeat (25) send_burst(1'b1, ($urandom_range(0, 7) == 0) ? 12 : $urandom_range(1, 6), 2, 32'd0, -1);
        done_b = 1'b1;
      end
      begin
        while (!(done_a && done_b)) begin
          @(posedge clk); #1;
          out_ready = ($urandom_range(0, 3) != 0);
        end
        out_ready = 1'b1;
      end
    join
    drain_and_clear();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
